// File: rtl/alu_pipe_mc_if.sv
// Request/response bundle for alu_pipe_mc: valid/ready request channel with op and
// operands, valid/ready result channel with result and status flags.
interface alu_pipe_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow, illegal
  );
endinterface

// File: rtl/alu_pipe_mc.sv
// Registered ALU for the EX stage: AND/OR/ADD/SUB/SLT in one cycle, unsigned MUL as
// a WIDTH-iteration shift-add that holds off new requests until its result is posted.
module alu_pipe_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  alu_pipe_mc_if.slave bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  logic               vld_p1;
  logic [WIDTH-1:0]   res_p1;
  logic               zero_p1;
  logic               carry_p1;
  logic               ovf_p1;
  logic               ill_p1;

  logic               in_ready_w;
  logic [WIDTH:0]     sum_add;
  logic [WIDTH:0]     sum_sub;
  logic [WIDTH-1:0]   res_c;
  logic               carry_c;
  logic               ovf_c;
  logic               ill_c;
  logic               ovf_sub;

  // Signed overflow: operands share a sign that the sum does not.
  function automatic logic sgn_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] s);
    return ((x < 0) == (y < 0)) && ((s < 0) != (x < 0));
  endfunction

  assign in_ready_w = (state == IDLE) && (!vld_p1 || bus.out_ready);
  assign sum_add    = {1'b0, bus.a} + {1'b0, bus.b};
  assign sum_sub    = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
  assign ovf_sub    = sgn_ovf($signed(bus.a), $signed(~bus.b), $signed(sum_sub[WIDTH-1:0]));

  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    ill_c   = 1'b0;
    case (bus.op)
      OP_AND: res_c = bus.a & bus.b;
      OP_OR:  res_c = bus.a | bus.b;
      OP_ADD: begin
        res_c   = sum_add[WIDTH-1:0];
        carry_c = sum_add[WIDTH];
        ovf_c   = sgn_ovf($signed(bus.a), $signed(bus.b), $signed(sum_add[WIDTH-1:0]));
      end
      OP_SUB: begin
        res_c   = sum_sub[WIDTH-1:0];
        carry_c = sum_sub[WIDTH];
        ovf_c   = ovf_sub;
      end
      OP_SLT: begin
        res_c   = {{(WIDTH-1){1'b0}}, sum_sub[WIDTH-1] ^ ovf_sub};
        carry_c = sum_sub[WIDTH];
      end
      OP_MUL:  res_c = '0;
      default: ill_c = 1'b1;
    endcase
  end

  // Stage p1: handshake state, multiply iteration and registered result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      vld_p1   <= 1'b0;
      res_p1   <= '0;
      zero_p1  <= 1'b0;
      carry_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
      ill_p1   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_w) begin
            if (bus.op == OP_MUL) begin
              state  <= MUL;
              mcand  <= {{WIDTH{1'b0}}, bus.a};
              mplier <= bus.b;
              acc    <= '0;
              cnt    <= CNT_W'(WIDTH);
              vld_p1 <= 1'b0;
            end else begin
              vld_p1   <= 1'b1;
              res_p1   <= res_c;
              zero_p1  <= (res_c == '0);
              carry_p1 <= carry_c;
              ovf_p1   <= ovf_c;
              ill_p1   <= ill_c;
            end
          end else if (vld_p1 && bus.out_ready) begin
            vld_p1 <= 1'b0;
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          res_p1   <= acc[WIDTH-1:0];
          zero_p1  <= (acc[WIDTH-1:0] == '0);
          carry_p1 <= 1'b0;
          ovf_p1   <= |acc[2*WIDTH-1:WIDTH];
          ill_p1   <= 1'b0;
          vld_p1   <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = vld_p1;
  assign bus.result    = res_p1;
  assign bus.zero      = zero_p1;
  assign bus.carry     = carry_p1;
  assign bus.overflow  = ovf_p1;
  assign bus.illegal   = ill_p1;

endmodule

// File: tb/tb_alu_pipe_mc.sv
// Directed bench for alu_pipe_mc: a 32-bit and an 8-bit instance driven through
// hand-computed vectors, checked with immediate assertions.
module tb_alu_pipe_mc;

  logic clk = 1'b0;
  logic rst32;
  logic rst8;
  int   errors = 0;
  int   checks = 0;

  alu_pipe_mc_if #(.WIDTH(32)) b32 ();
  alu_pipe_mc_if #(.WIDTH(8))  b8 ();

  alu_pipe_mc #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst32), .bus(b32));
  alu_pipe_mc #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(b8));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    b32.in_valid = 1'b1;
    b32.op = op;
    b32.a = a;
    b32.b = b;
  endtask

  initial begin
    int lat;
    int busy_bad;
    logic [31:0] held;

    rst32 = 1'b1;
    rst8  = 1'b1;
    b32.in_valid = 1'b0; b32.op = 4'h0; b32.a = '0; b32.b = '0; b32.out_ready = 1'b1;
    b8.in_valid  = 1'b0; b8.op  = 4'h0; b8.a  = '0; b8.b  = '0; b8.out_ready  = 1'b1;
    step();
    step();
    chk("rst_out_valid", b32.out_valid, 0);
    chk("rst_result",    b32.result, 0);
    chk("rst_flags",     {b32.zero, b32.carry, b32.overflow, b32.illegal}, 0);
    rst32 = 1'b0;
    rst8  = 1'b0;
    step();
    chk("idle_in_ready", b32.in_ready, 1);

    // ADD with signed overflow
    req32(4'b0010, 32'h7FFF_FFFF, 32'h1);
    step();
    chk("add_valid",  b32.out_valid, 1);
    chk("add_result", b32.result, 64'h8000_0000);
    chk("add_flags",  {b32.zero, b32.carry, b32.overflow, b32.illegal}, 4'b0010);

    req32(4'b0110, 32'd5, 32'd5);
    step();
    chk("sub_result", b32.result, 0);
    chk("sub_flags",  {b32.zero, b32.carry, b32.overflow, b32.illegal}, 4'b1100);

    req32(4'b0111, 32'h8000_0000, 32'h1);
    step();
    chk("slt_neg_lt", b32.result, 1);
    chk("slt_neg_ovf", b32.overflow, 0);

    req32(4'b0111, 32'h1, 32'h8000_0000);
    step();
    chk("slt_pos_ge", b32.result, 0);

    // back-to-back single-cycle ops
    req32(4'b0000, 32'h0F0F, 32'h00FF);
    step();
    chk("and_result", b32.result, 64'h000F);
    chk("and_ready",  b32.in_ready, 1);
    req32(4'b0001, 32'h0F0F, 32'h00FF);
    step();
    chk("or_result", b32.result, 64'h0FFF);
    chk("or_valid",  b32.out_valid, 1);
    req32(4'b0010, 32'h0F0F, 32'h00FF);
    step();
    chk("add2_result", b32.result, 64'h100E);
    chk("add2_ready",  b32.in_ready, 1);
    b32.in_valid = 1'b0;
    step();
    chk("drain_valid", b32.out_valid, 0);
    chk("drain_hold",  b32.result, 64'h100E);

    // MUL with consumer stalled; a pending ADD must be ignored while busy
    b32.out_ready = 1'b0;
    req32(4'b1000, 32'h0001_0000, 32'h0001_0003);
    step();
    req32(4'b0010, 32'h1, 32'h1);
    lat = 0;
    busy_bad = 0;
    while (b32.out_valid !== 1'b1 && lat < 100) begin
      if (b32.in_ready !== 1'b0) busy_bad++;
      lat++;
      step();
    end
    chk("mul32_latency", lat, 33);
    chk("mul32_busy",    busy_bad, 0);
    chk("mul32_result",  b32.result, 64'h0003_0000);
    chk("mul32_flags",   {b32.zero, b32.carry, b32.overflow, b32.illegal}, 4'b0010);
    held = b32.result;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mul32_hold_res", b32.result, held);
      chk("mul32_hold_vld", b32.out_valid, 1);
    end
    chk("mul32_stall_ready", b32.in_ready, 0);
    b32.in_valid = 1'b0;
    b32.out_ready = 1'b1;
    step();
    chk("mul32_consumed", b32.out_valid, 0);

    // illegal op, then a legal op clears the flag
    req32(4'b0101, 32'h3, 32'h4);
    step();
    chk("ill_result", b32.result, 0);
    chk("ill_flags",  {b32.zero, b32.carry, b32.overflow, b32.illegal}, 4'b1001);
    req32(4'b0010, 32'h3, 32'h4);
    step();
    chk("ill_clear_res",  b32.result, 7);
    chk("ill_clear_flag", b32.illegal, 0);
    b32.in_valid = 1'b0;

    // 8-bit instance: MUL 15*17
    b8.in_valid = 1'b1; b8.op = 4'b1000; b8.a = 8'd15; b8.b = 8'd17;
    step();
    b8.in_valid = 1'b0;
    lat = 0;
    while (b8.out_valid !== 1'b1 && lat < 100) begin
      lat++;
      step();
    end
    chk("mul8_latency", lat, 9);
    chk("mul8_result",  b8.result, 64'hFF);
    chk("mul8_flags",   {b8.zero, b8.carry, b8.overflow, b8.illegal}, 4'b0000);

    // MUL 16*16 wraps to zero with overflow
    b8.in_valid = 1'b1; b8.op = 4'b1000; b8.a = 8'd16; b8.b = 8'd16;
    step();
    b8.in_valid = 1'b0;
    lat = 0;
    while (b8.out_valid !== 1'b1 && lat < 100) begin
      lat++;
      step();
    end
    chk("mul8_wrap_res",   b8.result, 0);
    chk("mul8_wrap_flags", {b8.zero, b8.carry, b8.overflow, b8.illegal}, 4'b1010);

    // reset aborts an in-flight multiply
    b8.in_valid = 1'b1; b8.op = 4'b1000; b8.a = 8'd7; b8.b = 8'd9;
    step();
    b8.in_valid = 1'b0;
    step();
    step();
    chk("mul8_busy", b8.in_ready, 0);
    step();
    rst8 = 1'b1;
    step();
    rst8 = 1'b0;
    chk("abort_valid", b8.out_valid, 0);
    chk("abort_ready", b8.in_ready, 1);
    step();
    chk("abort_stay_idle", b8.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe_mc.md
Name: alu_pipe_mc

Overview:
- Parametrised, registered successor to the bit-slice ALU used in the pipeline CPU datapath.
- Performs AND/OR/ADD/SUB/SLT in one registered cycle, and unsigned MUL as a multi-cycle shift-add operation.
- Uses a valid/ready handshake on both input and output, so it can sit in the EX stage and stall the pipeline during multiplies.
- Adds status flags (zero, carry, overflow, illegal op) that the single slice does not produce.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 4..64).
- CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter (derived; not to be overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept a request this cycle
- op  in  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 MUL; all other codes illegal
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- carry  out  1  ADD: carry-out; SUB/SLT: carry-out of a+~b+1 (1 = no borrow); else 0
- overflow  out  1  ADD/SUB: signed overflow; MUL: upper WIDTH bits of 2*WIDTH product nonzero; else 0
- illegal  out  1  the op was not a legal code

Behaviour:
- Reset is synchronous and active-high on clk. Reset values: state=IDLE, out_valid=0, result=0, all flags 0, counter=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Therefore in_ready is combinationally dependent on out_ready.
- A request is accepted when in_valid && in_ready at a rising edge. a, b and op are sampled only at acceptance.
- State IDLE, single-cycle op accepted:
  - result and flags are registered at the same edge; out_valid=1 in the next cycle (latency 1).
  - State stays IDLE, giving throughput of 1 op/cycle while out_ready=1.
- SLT: result = {(WIDTH-1) zeros, n^v}, where n is the sign bit and v the signed overflow of a-b. This is a correct signed compare, including overflow.
- Illegal op: result=0, zero=1, illegal=1, carry=0, overflow=0, latency 1; the block does not hang.
- State IDLE, MUL accepted:
  - Go to MUL. Load the multiplicand (zero-extended to 2*WIDTH), the multiplier, accumulator=0 and counter=WIDTH.
  - If out_valid was set and out_ready was high at that edge, out_valid drops to 0.
- State MUL, each cycle:
  - If multiplier LSB=1, accumulator += multiplicand.
  - Then multiplicand <<= 1, multiplier >>= 1, counter -= 1.
  - When counter reaches 1 (the last iteration), go to DONE.
- State DONE:
  - result = acc[WIDTH-1:0]; overflow = |acc[2W-1:W]; zero computed on result; carry=0; out_valid=1.
  - Return to IDLE at the next edge.
  - Latency from accept to out_valid = WIDTH+1 cycles.
- While in MUL or DONE: in_ready=0 and new requests are ignored.
- out_valid stays high and result/flags hold stable until out_ready=1. The output is never overwritten while unconsumed.
- Simultaneous output consume and new accept in IDLE: the new result replaces the old one; out_valid stays 1.
- Output consumed with no new accept: out_valid goes to 0 next cycle; result holds its last value.
- Arithmetic is modulo 2^WIDTH; a and b are treated as two's complement for the overflow and SLT rules.
- rst asserted mid-MUL aborts the operation: state returns to IDLE, out_valid=0, and the partial product is discarded.

Test Plan:
- Reset, then ADD a=0x7FFFFFFF b=1 -> one cycle later: out_valid=1, result=0x80000000, overflow=1, carry=0, zero=0.
- SUB a=5 b=5 -> result=0, zero=1, carry=1, overflow=0. Then SLT a=0x80000000 b=1 -> result=1. Then SLT a=1 b=0x80000000 -> result=0.
- Back-to-back AND, OR, ADD with out_ready tied 1 -> in_ready stays 1 and three results appear on consecutive cycles (0x0F0F&0x00FF=0x000F, then OR=0x0FFF, then ADD=0x100E).
- MUL a=0x00010000 b=0x00010003 at WIDTH=32 -> in_ready=0 for 33 cycles, then result=0x00030000 with overflow=1; out_ready held 0 keeps result stable for 5 cycles.
- WIDTH=8 instance: MUL 15*17 -> result=0xFF, overflow=0, latency 9. Assert rst on cycle 4 of a second MUL -> out_valid=0, in_ready=1 on the next cycle.
- op=0101 -> illegal=1, result=0, zero=1 after 1 cycle. A following legal ADD clears illegal.
